sr_flop_bank: RTL and testbench

SR_FLOP_BANK -- requirements
Module: sr_flop_bank

---
 rtl/sr_flop_bank.sv | 119 +++++++++++
 tb/tb_sr_flop_bank.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sr_flop_bank.sv
// Bank of independent SR flops with active-low set/reset requests, optional input
// synchronizers, configurable both-asserted resolution, edge pulses and conflict status.
module sr_flop_bank #(
  parameter int WIDTH         = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int CONFLICT_MODE = 0,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sbar,
  input  logic [WIDTH-1:0] rbar,
  input  logic             clr_status,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] q_rise,
  output logic [WIDTH-1:0] q_fall,
  output logic [WIDTH-1:0] conflict_sticky,
  output logic [CNT_W-1:0] conflict_cnt
);

  // A zero-stage build still declares one stage so the arrays stay legal; it is bypassed.
  localparam int SYNC_N = (SYNC_STAGES == 0) ? 1 : SYNC_STAGES;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] sbar_sync_q [SYNC_N];
  logic [WIDTH-1:0] sbar_sync_d [SYNC_N];
  logic [WIDTH-1:0] rbar_sync_q [SYNC_N];
  logic [WIDTH-1:0] rbar_sync_d [SYNC_N];

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] q_rise_q, q_rise_d;
  logic [WIDTH-1:0] q_fall_q, q_fall_d;
  logic [WIDTH-1:0] conflict_sticky_q, conflict_sticky_d;
  logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

  logic [WIDTH-1:0] set_act;
  logic [WIDTH-1:0] rst_act;
  logic [WIDTH-1:0] conflict;

  always_comb begin
    sbar_sync_d[0] = sbar;
    rbar_sync_d[0] = rbar;
    for (int k = 1; k < SYNC_N; k++) begin
      sbar_sync_d[k] = sbar_sync_q[k-1];
      rbar_sync_d[k] = rbar_sync_q[k-1];
    end
  end

  always_comb begin
    set_act  = ~((SYNC_STAGES == 0) ? sbar : sbar_sync_q[SYNC_N-1]);
    rst_act  = ~((SYNC_STAGES == 0) ? rbar : rbar_sync_q[SYNC_N-1]);
    conflict = set_act & rst_act;
  end

  always_comb begin
    q_d = q_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (set_act[i] && !rst_act[i]) begin
        q_d[i] = 1'b1;
      end else if (rst_act[i] && !set_act[i]) begin
        q_d[i] = 1'b0;
      end else if (conflict[i]) begin
        case (CONFLICT_MODE)
          1:       q_d[i] = 1'b1;
          2:       q_d[i] = 1'b0;
          3:       q_d[i] = ~q_q[i];
          default: q_d[i] = q_q[i];
        endcase
      end
    end
    q_rise_d = q_d & ~q_q;
    q_fall_d = ~q_d & q_q;
  end

  // A clear coinciding with a new conflict restarts the status from that conflict.
  always_comb begin
    conflict_sticky_d = conflict_sticky_q | conflict;
    conflict_cnt_d    = conflict_cnt_q;
    if (clr_status) begin
      conflict_sticky_d = conflict;
      conflict_cnt_d    = (|conflict) ? CNT_W'(1) : '0;
    end else if ((|conflict) && (conflict_cnt_q != CNT_MAX)) begin
      conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_N; k++) begin
        sbar_sync_q[k] <= '1;
        rbar_sync_q[k] <= '1;
      end
      q_q               <= '0;
      q_rise_q          <= '0;
      q_fall_q          <= '0;
      conflict_sticky_q <= '0;
      conflict_cnt_q    <= '0;
    end else begin
      for (int k = 0; k < SYNC_N; k++) begin
        sbar_sync_q[k] <= sbar_sync_d[k];
        rbar_sync_q[k] <= rbar_sync_d[k];
      end
      q_q               <= q_d;
      q_rise_q          <= q_rise_d;
      q_fall_q          <= q_fall_d;
      conflict_sticky_q <= conflict_sticky_d;
      conflict_cnt_q    <= conflict_cnt_d;
    end
  end

  assign q               = q_q;
  assign qbar            = ~q_q;
  assign q_rise          = q_rise_q;
  assign q_fall          = q_fall_q;
  assign conflict_sticky = conflict_sticky_q;
  assign conflict_cnt    = conflict_cnt_q;

endmodule

// File: tb/tb_sr_flop_bank.sv
// Four sr_flop_bank builds (one per conflict mode, mixed sync depths and counter widths)
// driven by shared random requests and compared every cycle against a history-based model.
module tb_sr_flop_bank;

  logic       clk;
  logic       rst_n;
  logic [3:0] sbar;
  logic [3:0] rbar;
  logic       clr_status;

  logic [3:0] q_o  [4];
  logic [3:0] qb_o [4];
  logic [3:0] qr_o [4];
  logic [3:0] qf_o [4];
  logic [3:0] st_o [4];
  logic [7:0] cnt0;
  logic [1:0] cnt1;
  logic [3:0] cnt2;
  logic [7:0] cnt3;

  int total = 0;
  int bad   = 0;

  sr_flop_bank #(.WIDTH(4), .SYNC_STAGES(2), .CONFLICT_MODE(0), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .sbar(sbar), .rbar(rbar), .clr_status(clr_status),
    .q(q_o[0]), .qbar(qb_o[0]), .q_rise(qr_o[0]), .q_fall(qf_o[0]),
    .conflict_sticky(st_o[0]), .conflict_cnt(cnt0));
  sr_flop_bank #(.WIDTH(4), .SYNC_STAGES(1), .CONFLICT_MODE(1), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .sbar(sbar), .rbar(rbar), .clr_status(clr_status),
    .q(q_o[1]), .qbar(qb_o[1]), .q_rise(qr_o[1]), .q_fall(qf_o[1]),
    .conflict_sticky(st_o[1]), .conflict_cnt(cnt1));
  sr_flop_bank #(.WIDTH(4), .SYNC_STAGES(0), .CONFLICT_MODE(2), .CNT_W(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .sbar(sbar), .rbar(rbar), .clr_status(clr_status),
    .q(q_o[2]), .qbar(qb_o[2]), .q_rise(qr_o[2]), .q_fall(qf_o[2]),
    .conflict_sticky(st_o[2]), .conflict_cnt(cnt2));
  sr_flop_bank #(.WIDTH(4), .SYNC_STAGES(3), .CONFLICT_MODE(3), .CNT_W(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .sbar(sbar), .rbar(rbar), .clr_status(clr_status),
    .q(q_o[3]), .qbar(qb_o[3]), .q_rise(qr_o[3]), .q_fall(qf_o[3]),
    .conflict_sticky(st_o[3]), .conflict_cnt(cnt3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: every sampled input is logged; a build with S sync stages acts at
  // edge n on the sample from edge n-S, or on idle inputs if that predates a reset.
  logic [7:0] hist [$];
  int         rst_edge;
  logic [3:0] m_q [4], m_rise [4], m_fall [4], m_stk [4];
  int         m_cnt [4];

  function automatic int ss(input int d);
    case (d)
      0: return 2;
      1: return 1;
      2: return 0;
      default: return 3;
    endcase
  endfunction

  function automatic int cnt_max(input int d);
    case (d)
      0: return 255;
      1: return 3;
      2: return 15;
      default: return 255;
    endcase
  endfunction

  function automatic logic [31:0] dut_cnt(input int d);
    case (d)
      0: return {24'b0, cnt0};
      1: return {30'b0, cnt1};
      2: return {28'b0, cnt2};
      default: return {24'b0, cnt3};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    rst_edge = hist.size();
    for (int d = 0; d < 4; d++) begin
      m_q[d] = '0; m_rise[d] = '0; m_fall[d] = '0; m_stk[d] = '0; m_cnt[d] = 0;
    end
  endtask

  task automatic model_step();
    int n, k;
    logic [7:0] v;
    logic [3:0] s, r, c, nq;
    n = hist.size();
    hist.push_back({sbar, rbar});
    for (int d = 0; d < 4; d++) begin
      k = n - ss(d);
      v = (k >= rst_edge) ? hist[k] : 8'hFF;
      s = ~v[7:4];
      r = ~v[3:0];
      c = s & r;
      nq = m_q[d];
      for (int i = 0; i < 4; i++) begin
        if (s[i] && !r[i]) nq[i] = 1'b1;
        else if (r[i] && !s[i]) nq[i] = 1'b0;
        else if (c[i]) nq[i] = (d == 1) ? 1'b1 : (d == 2) ? 1'b0 : (d == 3) ? ~m_q[d][i] : m_q[d][i];
      end
      m_rise[d] = nq & ~m_q[d];
      m_fall[d] = ~nq & m_q[d];
      m_q[d] = nq;
      if (clr_status) begin
        m_stk[d] = c;
        m_cnt[d] = (c != 0) ? 1 : 0;
      end else begin
        m_stk[d] = m_stk[d] | c;
        if (c != 0 && m_cnt[d] < cnt_max(d)) m_cnt[d] = m_cnt[d] + 1;
      end
    end
  endtask

  task automatic check_all(input string p);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("%s_q%0d", p, d),      {28'b0, q_o[d]},  {28'b0, m_q[d]});
      chk($sformatf("%s_qbar%0d", p, d),   {28'b0, qb_o[d]}, {28'b0, ~m_q[d]});
      chk($sformatf("%s_rise%0d", p, d),   {28'b0, qr_o[d]}, {28'b0, m_rise[d]});
      chk($sformatf("%s_fall%0d", p, d),   {28'b0, qf_o[d]}, {28'b0, m_fall[d]});
      chk($sformatf("%s_sticky%0d", p, d), {28'b0, st_o[d]}, {28'b0, m_stk[d]});
      chk($sformatf("%s_cnt%0d", p, d),    dut_cnt(d),       32'(m_cnt[d]));
    end
  endtask

  always @(posedge clk) begin
    if (rst_n) model_step();
    #1 check_all("cyc");
  end

  task automatic cycle(input logic [3:0] sb, input logic [3:0] rb, input logic c);
    @(negedge clk);
    sbar = sb; rbar = rb; clr_status = c;
    @(posedge clk);
    #2;
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("arst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] sb, rb;
    rst_n = 1'b0; sbar = '1; rbar = '1; clr_status = 1'b0;
    model_reset();
    #1 check_all("rst");
    repeat (2) cycle('1, '1, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    // One-cycle set on channel 0 lands on the third edge for the two-stage build.
    cycle(4'b1110, 4'b1111, 1'b0);
    cycle(4'b1111, 4'b1111, 1'b0);
    cycle(4'b1111, 4'b1111, 1'b0);
    chk("set_q_dut0",    {28'b0, q_o[0]},  32'h1);
    chk("set_rise_dut0", {28'b0, qr_o[0]}, 32'h1);
    chk("set_qbar_dut0", {28'b0, qb_o[0]}, 32'he);
    cycle(4'b1111, 4'b1111, 1'b0);
    chk("set_rise_gone_dut0", {28'b0, qr_o[0]}, 32'h0);

    repeat (4) cycle(4'b1111, 4'b1111, 1'b0);
    repeat (4) cycle(4'b1110, 4'b1110, 1'b0);
    repeat (5) cycle(4'b1111, 4'b1111, 1'b0);
    chk("hold_cnt_dut0",    dut_cnt(0),       32'd4);
    chk("hold_sticky_dut0", {28'b0, st_o[0]}, 32'h1);

    repeat (6) cycle(4'b1001, 4'b1001, 1'b0);
    repeat (5) cycle(4'b1111, 4'b1111, 1'b0);
    chk("sat_cnt_dut1", dut_cnt(1), 32'd3);

    cycle(4'b0111, 4'b0111, 1'b1);
    repeat (4) cycle(4'b1111, 4'b1111, 1'b0);
    chk("clr_sticky_dut0", {28'b0, st_o[0]}, 32'h8);
    chk("clr_cnt_dut0",    dut_cnt(0),       32'd1);

    cycle(4'b0000, 4'b1111, 1'b0);
    async_reset();
    repeat (5) cycle(4'b1111, 4'b1111, 1'b0);

    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        async_reset();
      end else begin
        for (int i = 0; i < 4; i++) begin
          sb[i] = ($urandom_range(0, 3) != 0);
          rb[i] = ($urandom_range(0, 3) != 0);
        end
        cycle(sb, rb, ($urandom_range(0, 19) == 0));
      end
    end
    repeat (5) cycle('1, '1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
